maze_explorer: RTL and testbench
================================

MAZE_EXPLORER -- requirements
Module: maze_explorer

Interface
REQ-001 Parameters SHALL be: COORD_W, default 4, width of one maze coordinate; STACK_DEPTH, default 256, number of 2-bit direction stack entries.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: begin a search; sampled only in IDLE, DONE or FAIL.
REQ-005 Ports start_x and start_y, inputs, 4 bits each: start cell; latched when start is accepted.
REQ-006 Ports goal_x and goal_y, inputs, 4 bits each: goal cell; latched when start is accepted.
REQ-007 Port mem_dout, input, 1 bit: maze memory read data; 1 = wall or visited, 0 = free.
REQ-008 Port mem_loc, output, 8 bits: cell address {x,y}, with x in bits [7:4] and y in bits [3:0].
REQ-009 Port mem_rd, output, 1 bit: one-cycle read strobe to the maze memory.
REQ-010 Port mem_wr, output, 1 bit: one-cycle write strobe to the maze memory.
REQ-011 Port mem_din, output, 1 bit: write data; SHALL always be 1 when mem_wr is high.
REQ-012 Port busy, output, 1 bit: high while a search is in progress.
REQ-013 Port done, output, 1 bit: high (level) in DONE and FAIL until the next start is accepted.
REQ-014 Port found, output, 1 bit: high only in DONE, meaning the goal was reached.
REQ-015 Ports cur_x and cur_y, outputs, 4 bits each: current explorer position.
REQ-016 Port path_len, output, 9 bits: current direction stack depth, which equals the path length when found.

Function
REQ-017 States SHALL be IDLE, CHK_START, WAIT_START, MARK, PROBE_RD, PROBE_WAIT, MOVE, BACKTRACK, DONE, FAIL.
REQ-018 Memory protocol: mem_rd and mem_wr SHALL be mutually exclusive; mem_loc SHALL be valid in the same cycle as the strobe; mem_dout SHALL be sampled exactly one cycle after mem_rd.
REQ-019 When start is accepted, the block SHALL latch the start and goal cells, clear the stack, set cur to the start cell, and go to CHK_START.
REQ-020 CHK_START SHALL issue a read of the start cell; in WAIT_START, mem_dout=1 SHALL go to FAIL with no write issued, and mem_dout=0 SHALL go to MARK.
REQ-021 MARK SHALL write 1 to cur (visited mark), set the direction-try index to 0, and then go to DONE if cur equals goal, else to PROBE_RD.
REQ-022 Direction encoding SHALL be 0=E (y+1), 1=S (x+1), 2=W (y-1), 3=N (x-1), tried in ascending order.
REQ-023 In PROBE_RD, a neighbour outside 0..15 SHALL be skipped in the same cycle with no memory access, and the try index SHALL be incremented.
REQ-024 Otherwise PROBE_RD SHALL issue a read of the neighbour; PROBE_WAIT SHALL go to MOVE on mem_dout=0, and on 1 SHALL increment the try index and return to PROBE_RD.
REQ-025 MOVE SHALL push the direction, step cur one cell in that direction, and go to MARK.
REQ-026 When the try index passes 3, the block SHALL go to BACKTRACK.
REQ-027 BACKTRACK with an empty stack SHALL go to FAIL.
REQ-028 BACKTRACK with a non-empty stack SHALL pop direction d, step cur opposite to d, set the try index to d+1, and go to PROBE_RD; if d=3 the index overflows and the block SHALL backtrack again.
REQ-029 Visited marks guarantee depth never exceeds 255; a push with a full stack SHALL go to FAIL (defensive).
REQ-030 When start equals goal and the start cell is free, the block SHALL reach DONE with path_len=0 after exactly one write.
REQ-031 The map is modified destructively; restoring it is the system's job.
REQ-032 Cost: a probe SHALL take 2 cycles, a skipped neighbour 1 cycle, a mark 1 cycle, and a move or backtrack 1 cycle.
REQ-033 start asserted while busy SHALL be ignored.

Reset
REQ-034 On rst_n low, the block SHALL enter IDLE immediately.
REQ-035 During reset: mem_rd=0, mem_wr=0, mem_din=0, mem_loc=0, busy=0, done=0, found=0, cur_x=0, cur_y=0, path_len=0, stack pointer=0.
REQ-036 Reset mid-search SHALL abort without completing any pending access; map marks already written remain.
REQ-037 Release SHALL be usable synchronously on the first clk edge after rst_n rises.

Structure
REQ-038 A shared package SHALL hold the state enum, the direction encoding, COORD_W, and an opposite-direction function.
REQ-039 One sub-module, maze_dir_stack, SHALL implement the LIFO (STACK_DEPTH x 2 bits) with push, pop, top, empty, full and depth outputs, and asynchronous active-low reset of its pointer.

Verification
REQ-040 All-zero map, start (0,0), goal (0,3) -> found=1, path_len=3, cur=(0,3); exactly 4 writes to locs 0x00, 0x01, 0x02, 0x03.
REQ-041 Map with (0,0)=1, start (0,0) -> FAIL, done=1, found=0, zero mem_wr pulses, done within 3 cycles.
REQ-042 Goal (15,15) enclosed by walls on (14,15) and (15,14), start (0,0) -> FAIL after full backtrack, path_len=0, every reachable free cell now reads 1.
REQ-043 Dead-end branch east of start with the only route south -> found=1, and path_len equals the true path length after the branch is popped.
REQ-044 Start (5,5) = goal (5,5), free -> DONE, path_len=0, one write to 0x55.
REQ-045 rst_n pulsed low mid-probe -> all outputs zero in the same cycle; a new start then completes a correct search.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types for the maze explorer: FSM states, direction encoding,
// coordinate width and the opposite-direction helper.
package maze_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    CHK_START,
    WAIT_START,
    MARK,
    PROBE_RD,
    PROBE_WAIT,
    MOVE,
    BACKTRACK,
    DONE,
    FAIL
  } state_e;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_N = 2'd3
  } dir_e;

  // E<->W and S<->N differ only in bit 1
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit directions recording the explorer's path.
// Only the pointer is reset; entry storage is plain RAM.
module maze_dir_stack #(
  parameter int DEPTH = 256,
  parameter int PW    = $clog2(DEPTH + 1),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [1:0]    din,
  output logic [1:0]    top,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] depth
);

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW-1:0] sp_m1;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == PW'(DEPTH));
  assign depth = sp_q;
  assign sp_m1 = sp_q - PW'(1);
  assign top   = mem_q[sp_m1[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + PW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[sp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/maze_explorer.sv
// Depth-first maze explorer: marks visited cells in an external bit map
// and keeps its path as a stack of directions for backtracking.
module maze_explorer #(
  parameter int COORD_W     = maze_pkg::COORD_W,
  parameter int STACK_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [COORD_W-1:0]   start_x,
  input  logic [COORD_W-1:0]   start_y,
  input  logic [COORD_W-1:0]   goal_x,
  input  logic [COORD_W-1:0]   goal_y,
  input  logic                 mem_dout,
  output logic [2*COORD_W-1:0] mem_loc,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 mem_din,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [COORD_W-1:0]   cur_x,
  output logic [COORD_W-1:0]   cur_y,
  output logic [8:0]           path_len
);

  import maze_pkg::*;

  localparam int PW = $clog2(STACK_DEPTH + 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [1:0]         try_q, try_d;

  logic          st_clr, st_push, st_pop;
  logic [1:0]    st_top;
  logic          st_empty, st_full;
  logic [PW-1:0] st_depth;

  logic [COORD_W-1:0] nx, ny, bx, by;
  logic               nb_ok;

  maze_dir_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (st_clr),
    .push  (st_push),
    .pop   (st_pop),
    .din   (try_q),
    .top   (st_top),
    .empty (st_empty),
    .full  (st_full),
    .depth (st_depth)
  );

  function automatic logic [2*COORD_W-1:0] step(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input dir_e               d
  );
    logic [2*COORD_W-1:0] r;
    unique case (d)
      DIR_E:   r = {x, COORD_W'(y + 1'b1)};
      DIR_S:   r = {COORD_W'(x + 1'b1), y};
      DIR_W:   r = {x, COORD_W'(y - 1'b1)};
      default: r = {COORD_W'(x - 1'b1), y};
    endcase
    return r;
  endfunction

  // Neighbour under test, and its in-bounds check
  always_comb begin
    {nx, ny} = step(cx_q, cy_q, dir_e'(try_q));
    unique case (dir_e'(try_q))
      DIR_E:   nb_ok = (cy_q != '1);
      DIR_S:   nb_ok = (cx_q != '1);
      DIR_W:   nb_ok = (cy_q != '0);
      default: nb_ok = (cx_q != '0);
    endcase
  end

  assign {bx, by} = step(cx_q, cy_q, opposite(dir_e'(st_top)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      try_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      try_q   <= try_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    try_d   = try_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_din = 1'b0;
    mem_loc = '0;
    st_clr  = 1'b0;
    st_push = 1'b0;
    st_pop  = 1'b0;
    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          cx_d    = start_x;
          cy_d    = start_y;
          gx_d    = goal_x;
          gy_d    = goal_y;
          st_clr  = 1'b1;
          state_d = CHK_START;
        end
      end
      CHK_START: begin
        mem_rd  = 1'b1;
        mem_loc = {cx_q, cy_q};
        state_d = WAIT_START;
      end
      WAIT_START: begin
        state_d = mem_dout ? FAIL : MARK;
      end
      MARK: begin
        mem_wr  = 1'b1;
        mem_din = 1'b1;
        mem_loc = {cx_q, cy_q};
        try_d   = 2'd0;
        state_d = (cx_q == gx_q && cy_q == gy_q) ? DONE : PROBE_RD;
      end
      PROBE_RD: begin
        if (!nb_ok) begin
          try_d = try_q + 2'd1;
          if (try_q == 2'd3) state_d = BACKTRACK;
        end else begin
          mem_rd  = 1'b1;
          mem_loc = {nx, ny};
          state_d = PROBE_WAIT;
        end
      end
      PROBE_WAIT: begin
        if (!mem_dout) begin
          state_d = MOVE;
        end else begin
          try_d   = try_q + 2'd1;
          state_d = (try_q == 2'd3) ? BACKTRACK : PROBE_RD;
        end
      end
      MOVE: begin
        if (st_full) begin
          state_d = FAIL;
        end else begin
          st_push = 1'b1;
          cx_d    = nx;
          cy_d    = ny;
          state_d = MARK;
        end
      end
      BACKTRACK: begin
        if (st_empty) begin
          state_d = FAIL;
        end else begin
          // A popped N has no directions left: unwind another level
          st_pop  = 1'b1;
          cx_d    = bx;
          cy_d    = by;
          try_d   = st_top + 2'd1;
          state_d = (st_top == 2'd3) ? BACKTRACK : PROBE_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = !(state_q inside {IDLE, DONE, FAIL});
  assign done     = (state_q == DONE) || (state_q == FAIL);
  assign found    = (state_q == DONE);
  assign cur_x    = cx_q;
  assign cur_y    = cy_q;
  assign path_len = 9'(st_depth);

endmodule

// File: tb/tb_maze_explorer.sv
// Scoreboard bench for maze_explorer: a DFS reference model predicts
// each search outcome; a monitor compares when done rises.
module tb_maze_explorer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_x = '0, start_y = '0;
  logic [3:0] goal_x = '0, goal_y = '0;
  logic       mem_dout = 1'b0;
  logic [7:0] mem_loc;
  logic       mem_rd, mem_wr, mem_din;
  logic       busy, done, found;
  logic [3:0] cur_x, cur_y;
  logic [8:0] path_len;

  always #5 clk = ~clk;

  maze_explorer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .start_x  (start_x),
    .start_y  (start_y),
    .goal_x   (goal_x),
    .goal_y   (goal_y),
    .mem_dout (mem_dout),
    .mem_loc  (mem_loc),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .path_len (path_len)
  );

  // Maze memory: one-cycle read latency, bulk load from the stimulus
  logic [255:0] mem = '0;
  logic [255:0] ld_map = '0;
  logic         ld = 1'b0;

  always @(posedge clk) begin
    if (ld) mem <= ld_map;
    else if (mem_wr) mem[mem_loc] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_loc];
  end

  typedef struct {
    bit           found;
    int           plen;
    int           cx;
    int           cy;
    int           writes;
    int           cycles;
    logic [255:0] map;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference: plain DFS over coordinates, E,S,W,N order, with cycle costs
  task automatic model(input int sx, input int sy, input int gx,
                       input int gy, output exp_t e);
    logic [255:0] m;
    int px[$], py[$], pd[$];
    int dx[4], dy[4];
    int cx, cy, d, nx, ny;
    bit fin;
    dx = '{0, 1, 0, -1};
    dy = '{1, 0, -1, 0};
    m = mem;
    e.found = 0; e.writes = 0; e.cycles = 2;
    cx = sx; cy = sy;
    fin = m[sx*16+sy];
    if (!fin) begin
      m[cx*16+cy] = 1'b1;
      e.writes = 1; e.cycles += 1; d = 0;
      fin = (cx == gx && cy == gy);
      e.found = fin;
    end
    while (!fin) begin
      if (d == 4) begin
        e.cycles += 1;
        if (px.size() == 0) begin
          fin = 1;
        end else begin
          cx = px.pop_back(); cy = py.pop_back(); d = pd.pop_back() + 1;
        end
      end else begin
        nx = cx + dx[d]; ny = cy + dy[d];
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          e.cycles += 1; d++;
        end else begin
          e.cycles += 2;
          if (m[nx*16+ny]) begin
            d++;
          end else begin
            e.cycles += 2;
            px.push_back(cx); py.push_back(cy); pd.push_back(d);
            cx = nx; cy = ny; d = 0;
            m[cx*16+cy] = 1'b1;
            e.writes++;
            if (cx == gx && cy == gy) begin
              fin = 1; e.found = 1;
            end
          end
        end
      end
    end
    e.plen = px.size();
    e.cx = cx; e.cy = cy; e.map = m;
  endtask

  task automatic chk(input string n, input int act, input int expv);
    vecs++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, act, expv);
    end
  endtask

  // Monitor
  int cyc = 0, wrs = 0, bad = 0;
  bit busy_p = 0, done_p = 0;
  initial begin
    exp_t e;
    int ndiff;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (!rst_n) begin
        chk("reset_outputs",
            int'({mem_rd, mem_wr, mem_din, mem_loc, busy, done, found,
                  cur_x, cur_y, path_len}), 0);
        busy_p = 0; done_p = 0;
      end else begin
        if (busy && !busy_p) begin
          cyc = 0; wrs = 0; bad = 0;
        end
        if (busy) cyc++;
        if (mem_wr) wrs++;
        if ((mem_rd && mem_wr) || (mem_wr && !mem_din)) bad++;
        if (done && !done_p) begin
          if (sbq.size() == 0) begin
            vecs++; errs++;
            $display("FAIL unexpected_done: no search pending");
          end else begin
            e = sbq.pop_front();
            chk("found", int'(found), int'(e.found));
            chk("path_len", int'(path_len), e.plen);
            chk("cur_x", int'(cur_x), e.cx);
            chk("cur_y", int'(cur_y), e.cy);
            chk("writes", wrs, e.writes);
            chk("cycles", cyc, e.cycles);
            chk("protocol_violations", bad, 0);
            ndiff = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== e.map[i]) ndiff++;
            chk("map_cells_differing", ndiff, 0);
          end
        end
        busy_p = busy; done_p = done;
      end
    end
  end

  task automatic load(input logic [255:0] m);
    @(negedge clk); ld_map = m; ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic issue(input int sx, input int sy, input int gx, input int gy);
    @(negedge clk);
    start = 1'b1;
    start_x = 4'(sx); start_y = 4'(sy);
    goal_x = 4'(gx); goal_y = 4'(gy);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic search(input int sx, input int sy, input int gx, input int gy);
    exp_t e;
    bit ok;
    model(sx, sy, gx, gy, e);
    sbq.push_back(e);
    issue(sx, sy, gx, gy);
    ok = 0;
    for (int i = 0; i < 10000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) begin
      $display("FAIL timeout: done not seen for search (%0d,%0d)->(%0d,%0d)",
               sx, sy, gx, gy);
      $fatal(1);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [255:0] m;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    load('0);
    search(0, 0, 0, 3);

    m = '0; m[0] = 1'b1;
    load(m);
    search(0, 0, 5, 5);

    m = '0; m[14*16+15] = 1'b1; m[15*16+14] = 1'b1;
    load(m);
    search(0, 0, 15, 15);

    m = '1;
    m[0*16+0] = 1'b0; m[0*16+1] = 1'b0; m[0*16+2] = 1'b0;
    m[1*16+0] = 1'b0; m[2*16+0] = 1'b0; m[3*16+0] = 1'b0;
    load(m);
    search(0, 0, 3, 0);

    load('0);
    search(5, 5, 5, 5);

    // Abort mid-probe, then a fresh search on the partly marked map
    load('0);
    issue(0, 0, 15, 15);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    search(10, 10, 12, 5);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) m[i] = ($urandom_range(99) < 30);
      load(m);
      search($urandom_range(15), $urandom_range(15),
             $urandom_range(15), $urandom_range(15));
    end

    if (sbq.size() != 0) begin
      vecs++; errs++;
      $display("FAIL pending: %0d searches never completed", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
